// File: rtl/min_tree_pipe_if.sv
// Stream bundle for the arg-min engine: beat input side and search-result output side.
interface min_tree_pipe_if #(
    parameter int ELEMENT_BIT_DEPTH = 14,
    parameter int LOG2_ELEMENTS     = 4,
    parameter int LOG2_BEATS        = 2
);
    logic                                          in_valid;
    logic                                          in_ready;
    logic [ELEMENT_BIT_DEPTH*(2**LOG2_ELEMENTS)-1:0] in_array;
    logic                                          out_valid;
    logic                                          out_ready;
    logic [ELEMENT_BIT_DEPTH-1:0]                  out_min;
    logic [LOG2_BEATS+LOG2_ELEMENTS-1:0]           out_index;

    // Producer of beats / consumer of results.
    modport master (
        output in_valid, in_array, out_ready,
        input  in_ready, out_valid, out_min, out_index
    );

    // The engine itself.
    modport slave (
        input  in_valid, in_array, out_ready,
        output in_ready, out_valid, out_min, out_index
    );
endinterface

// File: rtl/min_tree_pipe.sv
// Pipelined arg-min: input register, one compare-tree level per stage, then a
// running accumulator that folds 2**LOG2_BEATS beats into one {min, index} result.
module min_tree_pipe #(
    parameter int ELEMENT_BIT_DEPTH = 14,
    parameter int LOG2_ELEMENTS     = 4,
    parameter int LOG2_BEATS        = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    min_tree_pipe_if.slave bus
);
    localparam int W  = ELEMENT_BIT_DEPTH;
    localparam int L  = LOG2_ELEMENTS;
    localparam int LB = LOG2_BEATS;
    localparam int N  = 1 << L;

    logic                   stall;
    logic                   accept;
    logic [LB-1:0]          beat_cnt;
    logic [L:0]             vld_pipe;
    logic [L:0][LB-1:0]     tag_pipe;
    logic [N-1:0][W-1:0]    s0_val;
    logic [N-1:0][L-1:0]    s0_idx;

    logic [W-1:0]           fin_val;
    logic [L-1:0]           fin_idx;
    logic [LB-1:0]          fin_tag;
    logic [W-1:0]           acc_min;
    logic [LB+L-1:0]        acc_idx;
    logic                   take;
    logic [W-1:0]           fold_min;
    logic [LB+L-1:0]        fold_idx;

    logic                   out_valid_q;
    logic [W-1:0]           out_min_q;
    logic [LB+L-1:0]        out_index_q;

    // A result the sink has not taken freezes the whole pipe.
    assign stall        = out_valid_q && !bus.out_ready;
    assign bus.in_ready = rst_n && !stall;
    assign accept       = bus.in_valid && bus.in_ready;

    assign bus.out_valid = out_valid_q;
    assign bus.out_min   = out_min_q;
    assign bus.out_index = out_index_q;

    // Each element carries its own position; tree nodes just forward the winner's.
    always_comb begin
        s0_idx = '0;
        for (int e = 0; e < N; e++) s0_idx[e] = L'(e);
    end

    // Input register, valid/tag shift register and beat counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_pipe <= '0;
            tag_pipe <= '0;
            beat_cnt <= '0;
            s0_val   <= '0;
        end else if (!stall) begin
            vld_pipe <= {vld_pipe[L-1:0], accept};
            tag_pipe <= {tag_pipe[L-1:0], beat_cnt};
            if (accept) begin
                s0_val   <= bus.in_array;
                beat_cnt <= beat_cnt + 1'b1;
            end
        end
    end

    for (genvar k = 1; k <= L; k++) begin : g_lvl
        localparam int NK = N >> k;
        logic [2*NK-1:0][W-1:0] src_val;
        logic [2*NK-1:0][L-1:0] src_idx;
        logic [NK-1:0][W-1:0]   cmp_val;
        logic [NK-1:0][L-1:0]   cmp_idx;
        logic [NK-1:0][W-1:0]   val_q;
        logic [NK-1:0][L-1:0]   idx_q;

        if (k == 1) begin : g_src
            assign src_val = s0_val;
            assign src_idx = s0_idx;
        end else begin : g_src
            assign src_val = g_lvl[k-1].val_q;
            assign src_idx = g_lvl[k-1].idx_q;
        end

        // Right operand only wins when strictly smaller, so ties keep the lower index.
        for (genvar j = 0; j < NK; j++) begin : g_node
            logic b_wins;
            assign b_wins     = src_val[2*j+1] < src_val[2*j];
            assign cmp_val[j] = b_wins ? src_val[2*j+1] : src_val[2*j];
            assign cmp_idx[j] = b_wins ? src_idx[2*j+1] : src_idx[2*j];
        end

        // Level register; data moves with the valid bits and holds on stall.
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                val_q <= '0;
                idx_q <= '0;
            end else if (!stall) begin
                val_q <= cmp_val;
                idx_q <= cmp_idx;
            end
        end
    end

    assign fin_val = g_lvl[L].val_q[0];
    assign fin_idx = g_lvl[L].idx_q[0];
    assign fin_tag = tag_pipe[L];

    // Beat 0 always loads; later beats replace only on strictly smaller cost.
    always_comb begin
        take     = (fin_tag == '0) || (fin_val < acc_min);
        fold_min = take ? fin_val : acc_min;
        fold_idx = take ? {fin_tag, fin_idx} : acc_idx;
    end

    // Accumulator and result register; last beat publishes the folded result.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_min     <= '0;
            acc_idx     <= '0;
            out_valid_q <= 1'b0;
            out_min_q   <= '0;
            out_index_q <= '0;
        end else if (!stall) begin
            // Not stalled means the output is empty or being taken this edge.
            out_valid_q <= 1'b0;
            if (vld_pipe[L]) begin
                acc_min <= fold_min;
                acc_idx <= fold_idx;
                if (fin_tag == {LB{1'b1}}) begin
                    out_valid_q <= 1'b1;
                    out_min_q   <= fold_min;
                    out_index_q <= fold_idx;
                end
            end
        end
    end
endmodule

// File: tb/tb_min_tree_pipe.sv
// Directed-table plus random bench for min_tree_pipe with a linear-scan reference model.
module tb_min_tree_pipe;
    localparam int W  = 14;
    localparam int LE = 4;
    localparam int LB = 2;
    localparam int N  = 16;
    localparam int B  = 4;
    localparam int IW = W * N;
    localparam int XW = LB + LE;
    localparam int NV = 10;

    typedef struct {
        int base;
        int b0; int e0; int v0;
        int b1; int e1; int v1;
        int emin;
        int eidx;
    } vec_t;

    typedef struct {
        int mn;
        int ix;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    min_tree_pipe_if #(.ELEMENT_BIT_DEPTH(W), .LOG2_ELEMENTS(LE), .LOG2_BEATS(LB)) bus ();

    min_tree_pipe #(.ELEMENT_BIT_DEPTH(W), .LOG2_ELEMENTS(LE), .LOG2_BEATS(LB)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    vec_t          tbl [NV];
    exp_t          q [$];
    logic [IW-1:0] cur [B];

    int errors = 0, checks = 0;
    int cyc = 0, last_acc = 0, rise_edge = -1, n_out = 0, stall_cycles = 0;
    int rdy_mode = 0, bp_cnt = 0;
    bit bp_done = 0, accepted = 0, prev_stall = 0, prev_ov = 0;
    logic [W-1:0]  held_min;
    logic [XW-1:0] held_idx;

    task automatic check_eq(input string nm, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: actual=%0d required=%0d (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    task automatic monitor();
        exp_t x;
        check_eq("in_ready", int'(bus.in_ready),
                 int'(rst_n && !(bus.out_valid && !bus.out_ready)));
        if (rst_n && !bus.in_ready) stall_cycles++;
        if (rst_n && prev_stall) begin
            check_eq("hold_valid", int'(bus.out_valid), 1);
            check_eq("hold_min", int'(bus.out_min), int'(held_min));
            check_eq("hold_idx", int'(bus.out_index), int'(held_idx));
        end
        if (rst_n && bus.out_valid && !prev_ov && rise_edge < 0) rise_edge = cyc;
        if (rst_n && bus.out_valid && bus.out_ready) begin
            n_out++;
            if (q.size() == 0) begin
                check_eq("unexpected_result", 1, 0);
            end else begin
                x = q.pop_front();
                check_eq("result_min", int'(bus.out_min), x.mn);
                check_eq("result_idx", int'(bus.out_index), x.ix);
            end
        end
        prev_ov    = rst_n && bus.out_valid;
        prev_stall = rst_n && bus.out_valid && !bus.out_ready;
        held_min   = bus.out_min;
        held_idx   = bus.out_index;
    endtask

    task automatic drive_ready();
        case (rdy_mode)
            1: bus.out_ready = ($urandom_range(0, 3) != 0);
            2: begin
                if (bp_cnt > 0) begin
                    bus.out_ready = 1'b0;
                    bp_cnt--;
                end else if (!bp_done && bus.out_valid) begin
                    bp_done = 1;
                    bus.out_ready = 1'b0;
                    bp_cnt = 9;
                end else begin
                    bus.out_ready = 1'b1;
                end
            end
            default: bus.out_ready = 1'b1;
        endcase
        if (rdy_mode != 2) begin
            bp_done = 0;
            bp_cnt  = 0;
        end
    endtask

    // One clock: check at the falling edge, then update drivers just after the rising edge.
    task automatic tick();
        @(negedge clk);
        monitor();
        accepted = bus.in_valid && bus.in_ready;
        @(posedge clk);
        cyc++;
        #1;
        drive_ready();
    endtask

    task automatic send_beat(input logic [IW-1:0] d);
        int n;
        n = 0;
        bus.in_valid = 1'b1;
        bus.in_array = d;
        accepted = 0;
        while (!accepted && n < 500) begin
            tick();
            n++;
        end
        bus.in_valid = 1'b0;
        if (!accepted) check_eq("accept_timeout", 0, 1);
        last_acc = cyc;
    endtask

    task automatic send_search(input int gap_max);
        for (int b = 0; b < B; b++) begin
            if (gap_max > 0 && $urandom_range(0, 3) == 0)
                repeat ($urandom_range(1, gap_max)) tick();
            send_beat(cur[b]);
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q.size() != 0 || bus.out_valid) && n < 2000) begin
            tick();
            n++;
        end
        check_eq("drain_pending", q.size(), 0);
    endtask

    task automatic build(input vec_t v);
        int x;
        for (int b = 0; b < B; b++) begin
            for (int e = 0; e < N; e++) begin
                x = v.base;
                if (b == v.b0 && e == v.e0) x = v.v0;
                if (b == v.b1 && e == v.e1) x = v.v1;
                cur[b][e*W +: W] = x[W-1:0];
            end
        end
    endtask

    task automatic push_vec(input vec_t v);
        exp_t x;
        x.mn = v.emin;
        x.ix = v.eidx;
        q.push_back(x);
    endtask

    // Linear scan in {beat, element} order with strict less-than: earliest position wins ties.
    function automatic exp_t model();
        exp_t r;
        int v;
        r.mn = 0;
        r.ix = 0;
        for (int b = 0; b < B; b++) begin
            for (int e = 0; e < N; e++) begin
                v = int'(cur[b][e*W +: W]);
                if ((b == 0 && e == 0) || v < r.mn) begin
                    r.mn = v;
                    r.ix = b * N + e;
                end
            end
        end
        return r;
    endfunction

    initial begin
        vec_t rv;
        int   n0, mode;
        tbl[0] = '{100,     2, 5, 7,       -1, -1, 0,   7,       'h25};
        tbl[1] = '{50,      -1, -1, 0,     -1, -1, 0,   50,      0};
        tbl[2] = '{200,     1, 3, 9,       3, 3, 9,     9,       'h13};
        tbl[3] = '{'h3FFF,  3, 15, 'h3FFE, -1, -1, 0,   'h3FFE,  'h3F};
        tbl[4] = '{'h3FFF,  -1, -1, 0,     -1, -1, 0,   'h3FFF,  0};
        tbl[5] = '{1000,    0, 0, 5,       0, 1, 5,     5,       0};
        tbl[6] = '{500,     3, 0, 1,       2, 15, 1,    1,       'h2F};
        tbl[7] = '{0,       -1, -1, 0,     -1, -1, 0,   0,       0};
        tbl[8] = '{900,     1, 8, 20,      1, 7, 20,    20,      'h17};
        tbl[9] = '{800,     0, 2, 30,      3, 9, 29,    29,      'h39};

        bus.in_valid  = 1'b0;
        bus.in_array  = '0;
        bus.out_ready = 1'b0;

        // Reset state.
        repeat (3) tick();
        check_eq("rst_in_ready", int'(bus.in_ready), 0);
        check_eq("rst_out_valid", int'(bus.out_valid), 0);
        check_eq("rst_out_min", int'(bus.out_min), 0);
        check_eq("rst_out_index", int'(bus.out_index), 0);
        rst_n = 1'b1;
        tick();
        check_eq("post_rst_in_ready", int'(bus.in_ready), 1);

        // Single search and its latency.
        build(tbl[0]);
        push_vec(tbl[0]);
        rise_edge = -1;
        send_search(0);
        drain();
        check_eq("latency", rise_edge - last_acc, 5);

        // Remaining table entries back to back.
        n0 = n_out;
        for (int i = 1; i < NV; i++) begin
            build(tbl[i]);
            push_vec(tbl[i]);
            send_search(0);
        end
        drain();
        check_eq("table_count", n_out - n0, NV - 1);

        // Backpressure: three searches streamed while the sink stalls for 10 cycles.
        rdy_mode = 2;
        stall_cycles = 0;
        n0 = n_out;
        build(tbl[2]); push_vec(tbl[2]); send_search(0);
        build(tbl[3]); push_vec(tbl[3]); send_search(0);
        build(tbl[6]); push_vec(tbl[6]); send_search(0);
        drain();
        check_eq("bp_stall_cycles", stall_cycles, 10);
        check_eq("bp_count", n_out - n0, 3);
        rdy_mode = 0;
        tick();

        // Reset after two beats of a search; next search must start at beat 0.
        build(tbl[0]);
        send_beat(cur[0]);
        send_beat(cur[1]);
        rst_n = 1'b0;
        tick();
        tick();
        check_eq("mid_rst_out_valid", int'(bus.out_valid), 0);
        check_eq("mid_rst_out_min", int'(bus.out_min), 0);
        check_eq("mid_rst_out_index", int'(bus.out_index), 0);
        check_eq("mid_rst_in_ready", int'(bus.in_ready), 0);
        rst_n = 1'b1;
        tick();
        rv = '{300, 0, 1, 3, -1, -1, 0, 3, 1};
        build(rv);
        push_vec(rv);
        n0 = n_out;
        send_search(0);
        drain();
        repeat (8) tick();
        check_eq("rst_pulse_count", n_out - n0, 1);

        // Random searches with input gaps and sink toggling.
        rdy_mode = 1;
        for (int s = 0; s < 1000; s++) begin
            mode = $urandom_range(0, 2);
            for (int b = 0; b < B; b++) begin
                for (int e = 0; e < N; e++) begin
                    case (mode)
                        0:       cur[b][e*W +: W] = W'($urandom_range(0, 7));
                        1:       cur[b][e*W +: W] = W'($urandom_range(16376, 16383));
                        default: cur[b][e*W +: W] = W'($urandom_range(0, 16383));
                    endcase
                end
            end
            q.push_back(model());
            send_search(3);
        end
        drain();
        rdy_mode = 0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
